// File: rtl/timer_event_logger.sv
// Timestamps rising edges of event_in into a FIFO readable over a 16-bit Avalon-MM slave.
// Latency: readdata and irq are registered, one cycle after the access or state change.
// Backpressure: none; a push into a full FIFO is dropped and flagged sticky in STATUS.overflow.
module timer_event_logger #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write_n,
  input  logic [15:0] writedata,
  input  logic        event_in,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [31:0]   ts_cnt;
  logic          event_d;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic          overflow;
  logic          enable;
  logic          irq_en;
  logic [4:0]    thresh;
  logic [31:0]   snapshot;

  logic          wr_acc;
  logic          rd_acc;
  logic          empty;
  logic          full;
  logic          edge_det;
  logic          flush;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic          ovf_set;
  logic [31:0]   head;
  logic [4:0]    thresh_wr_val;
  logic [15:0]   rd_mux;
  logic          unused_wdata;

  assign unused_wdata = ^writedata[15:5];

  // Decode bus strobes and FIFO push/pop decisions; flush overrides both push and pop.
  always_comb begin
    wr_acc   = chipselect & ~write_n;
    rd_acc   = chipselect & read;
    empty    = (count == 5'd0);
    full     = (count == DEPTH_C);
    edge_det = event_in & ~event_d;
    flush    = wr_acc & (address == 3'd1) & writedata[2];
    pop      = rd_acc & (address == 3'd3) & ~empty & ~flush;
    push_req = edge_det & enable;
    push_ok  = push_req & (~full | pop) & ~flush;
    ovf_set  = push_req & full & ~pop & ~flush;
    head     = mem[rd_ptr];
  end

  // THRESH write value clamped into 1..DEPTH.
  always_comb begin
    thresh_wr_val = writedata[4:0];
    if (writedata[4:0] == 5'd0)
      thresh_wr_val = 5'd1;
    else if (writedata[4:0] > DEPTH_C)
      thresh_wr_val = DEPTH_C;
  end

  // Register read mux; reflects state before any same-cycle pop.
  always_comb begin
    rd_mux = 16'h0000;
    case (address)
      3'd0: rd_mux = {7'd0, count, 1'b0, overflow, full, empty};
      3'd1: rd_mux = {14'd0, irq_en, enable};
      3'd2: rd_mux = empty ? 16'h0000 : head[15:0];
      3'd3: rd_mux = empty ? 16'h0000 : head[31:16];
      3'd4: rd_mux = snapshot[15:0];
      3'd5: rd_mux = snapshot[31:16];
      3'd6: rd_mux = {11'd0, thresh};
      default: rd_mux = 16'h0000;
    endcase
  end

  // Free-running timestamp and one-cycle delayed event for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt  <= 32'd0;
      event_d <= 1'b0;
    end else begin
      ts_cnt  <= ts_cnt + 32'd1;
      event_d <= event_in;
    end
  end

  // FIFO storage; contents are don't-care after reset since pointers restart.
  always_ff @(posedge clk) begin
    if (!reset && push_ok)
      mem[wr_ptr] <= ts_cnt;
  end

  // FIFO pointers, occupancy and sticky overflow (a set beats a STATUS-write clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= 5'd0;
      end else begin
        if (push_ok)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        if (push_ok && !pop)
          count <= count + 5'd1;
        else if (pop && !push_ok)
          count <= count - 5'd1;
      end
      if (ovf_set)
        overflow <= 1'b1;
      else if (wr_acc && (address == 3'd0))
        overflow <= 1'b0;
    end
  end

  // Software-visible configuration registers and timestamp snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      thresh   <= 5'd1;
      snapshot <= 32'd0;
    end else if (wr_acc) begin
      if (address == 3'd1) begin
        enable <= writedata[0];
        irq_en <= writedata[1];
      end
      if (address == 3'd6)
        thresh <= thresh_wr_val;
      if ((address == 3'd4) || (address == 3'd5))
        snapshot <= ts_cnt;
    end
  end

  // Registered outputs: read data every cycle and level interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 16'h0000;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= irq_en & ((count >= thresh) | overflow);
    end
  end

endmodule

// File: tb/tb_timer_event_logger.sv
// Bench for timer_event_logger: directed scenarios plus randomized traffic vs a queue model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives one bus access per cycle.
module tb_timer_event_logger;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write_n;
  logic [15:0] writedata;
  logic        event_in;
  logic [15:0] readdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_ts;
  logic        m_evd;
  logic [31:0] q[$];
  logic        m_ovf;
  logic        m_en;
  logic        m_ien;
  int          m_thr;
  logic [31:0] m_snap;
  logic [15:0] m_rd;
  logic        m_irq;

  timer_event_logger #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read(read), .write_n(write_n), .writedata(writedata), .event_in(event_in),
    .readdata(readdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    bit wr, rd, edg, pop, flush, push, ovf_set;
    int n;
    int wd5;
    if (reset) begin
      m_ts = 0; m_evd = 0; q.delete(); m_ovf = 0; m_en = 0; m_ien = 0;
      m_thr = 1; m_snap = 0; m_rd = 0; m_irq = 0;
      return;
    end
    n   = q.size();
    wr  = chipselect && !write_n;
    rd  = chipselect && read;
    edg = event_in && !m_evd;
    case (address)
      3'd0: m_rd = 16'((n << 4) | (m_ovf << 2) | ((n == DEPTH) << 1) | (n == 0));
      3'd1: m_rd = {14'd0, m_ien, m_en};
      3'd2: m_rd = (n > 0) ? q[0][15:0] : 16'h0;
      3'd3: m_rd = (n > 0) ? q[0][31:16] : 16'h0;
      3'd4: m_rd = m_snap[15:0];
      3'd5: m_rd = m_snap[31:16];
      3'd6: m_rd = 16'(m_thr);
      default: m_rd = 16'h0;
    endcase
    m_irq   = m_ien && ((n >= m_thr) || m_ovf);
    pop     = rd && (address == 3'd3) && (n > 0);
    flush   = wr && (address == 3'd1) && writedata[2];
    push    = edg && m_en;
    ovf_set = 0;
    if (flush) q.delete();
    else begin
      if (push && n == DEPTH && !pop) ovf_set = 1;
      if (pop) void'(q.pop_front());
      if (push && !ovf_set) q.push_back(m_ts);
    end
    if (ovf_set) m_ovf = 1;
    else if (wr && address == 3'd0) m_ovf = 0;
    if (wr && address == 3'd1) begin
      m_en  = writedata[0];
      m_ien = writedata[1];
    end
    if (wr && address == 3'd6) begin
      wd5 = int'(writedata[4:0]);
      m_thr = (wd5 == 0) ? 1 : ((wd5 > DEPTH) ? DEPTH : wd5);
    end
    if (wr && (address == 3'd4 || address == 3'd5)) m_snap = m_ts;
    m_evd = event_in;
    m_ts  = m_ts + 32'd1;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    chipselect = 0; read = 0; write_n = 1; address = 0; writedata = 0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1; write_n = 0; read = 0; address = a; writedata = d;
    step();
    bus_idle();
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    chipselect = 1; read = 1; write_n = 1; address = a;
    step();
    d = readdata;
    bus_idle();
  endtask

  task automatic pulse();
    event_in = 1; step();
    event_in = 0; step();
  endtask

  task automatic do_reset();
    bus_idle(); event_in = 0; reset = 1;
    step(); step();
    reset = 0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    chipselect = 1; write_n = 0; address = 3'd1; writedata = 16'h0003; event_in = 1;
    reset = 1; step(); step();
    reset = 0; bus_idle(); event_in = 0;
    checks++; if (readdata !== 16'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 0000", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL reset_status: got %h expected 0001", d); end
    bus_read(3'd1, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_control: got %h expected 0000", d); end
    bus_read(3'd6, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL reset_thresh: got %h expected 0001", d); end
    bus_read(3'd5, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_snap_h: got %h expected 0000", d); end
    bus_write(3'd7, 16'hFFFF);
    bus_read(3'd7, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL addr7_read: got %h expected 0000", d); end
  endtask

  task automatic test_single_event();
    logic [15:0] d;
    int guard;
    do_reset();
    bus_write(3'd1, 16'h0001);
    guard = 0;
    while (m_ts != 32'd100 && guard < 300) begin step(); guard++; end
    checks++; if (m_ts != 32'd100) begin errors++; $display("FAIL single_wait_ts100: got %0d expected 100", m_ts); end
    event_in = 1; step(); step(); step();
    event_in = 0; step();
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0010) begin errors++; $display("FAIL single_status: got %h expected 0010", d); end
    bus_read(3'd2, d);
    checks++; if (d !== 16'h0064) begin errors++; $display("FAIL single_head_l: got %h expected 0064", d); end
    bus_read(3'd3, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL single_head_h: got %h expected 0000", d); end
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL single_status_after_pop: got %h expected 0001", d); end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    do_reset();
    bus_write(3'd1, 16'h0001);
    for (int i = 0; i < 9; i++) pulse();
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0086) begin errors++; $display("FAIL ovf_status: got %h expected 0086", d); end
    bus_write(3'd0, 16'h0000);
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0082) begin errors++; $display("FAIL ovf_clear: got %h expected 0082", d); end
    // Full FIFO: edge coincident with a HEAD_H pop.
    chipselect = 1; read = 1; address = 3'd3; event_in = 1;
    step();
    checks++; if (readdata !== m_rd) begin errors++; $display("FAIL full_pop_data: got %h expected %h", readdata, m_rd); end
    bus_idle(); event_in = 0; step();
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0082) begin errors++; $display("FAIL full_push_pop_status: got %h expected 0082", d); end
    bus_read(3'd2, d);
    checks++; if (d !== m_rd) begin errors++; $display("FAIL full_new_head: got %h expected %h", d, m_rd); end
  endtask

  task automatic test_irq_threshold();
    logic [15:0] d;
    do_reset();
    bus_write(3'd6, 16'h0003);
    bus_write(3'd1, 16'h0003);
    pulse(); pulse();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_below: got %b expected 0", irq); end
    event_in = 1; step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b expected 0", irq); end
    event_in = 0; step();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b expected 1", irq); end
    bus_read(3'd3, d);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold_on_pop: got %b expected 1", irq); end
    step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_deassert: got %b expected 0", irq); end
    bus_write(3'd6, 16'h0000);
    bus_read(3'd6, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL thresh_zero: got %h expected 0001", d); end
    bus_write(3'd6, 16'h001F);
    bus_read(3'd6, d);
    checks++; if (d !== 16'h0008) begin errors++; $display("FAIL thresh_clamp: got %h expected 0008", d); end
  endtask

  task automatic test_wrap();
    logic [15:0] d;
    int guard;
    do_reset();
    bus_write(3'd1, 16'h0001);
    force dut.ts_cnt = 32'hFFFF_FFF0;
    m_ts = 32'hFFFF_FFF0;
    #1;
    release dut.ts_cnt;
    bus_write(3'd5, 16'h0000);
    bus_read(3'd5, d);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL snap_h: got %h expected FFFF", d); end
    bus_read(3'd4, d);
    checks++; if (d !== 16'hFFF0) begin errors++; $display("FAIL snap_l: got %h expected FFF0", d); end
    guard = 0;
    while (m_ts != 32'd0 && guard < 64) begin step(); guard++; end
    event_in = 1; step();
    event_in = 0; step();
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0010) begin errors++; $display("FAIL wrap_status: got %h expected 0010", d); end
    bus_read(3'd2, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL wrap_head_l: got %h expected 0000", d); end
    bus_read(3'd3, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL wrap_head_h: got %h expected 0000", d); end
  endtask

  task automatic test_flush_reset();
    logic [15:0] d;
    do_reset();
    bus_write(3'd1, 16'h0001);
    pulse(); pulse();
    chipselect = 1; write_n = 0; address = 3'd1; writedata = 16'h0005; event_in = 1;
    step();
    bus_idle(); event_in = 0; step();
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL flush_status: got %h expected 0001", d); end
    bus_read(3'd1, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL flush_control: got %h expected 0001", d); end
    pulse();
    reset = 1; chipselect = 1; read = 1; address = 3'd3; event_in = 1;
    step();
    reset = 0; bus_idle(); event_in = 0;
    checks++; if (readdata !== 16'h0000) begin errors++; $display("FAIL midpop_reset_rd: got %h expected 0000", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midpop_reset_irq: got %b expected 0", irq); end
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL midpop_reset_status: got %h expected 0001", d); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      chipselect = ($urandom_range(0, 3) != 0);
      read       = $urandom_range(0, 1) == 1;
      write_n    = ($urandom_range(0, 2) != 0);
      address    = ($urandom_range(0, 2) == 0) ? 3'd3 : 3'($urandom_range(0, 7));
      writedata  = 16'($urandom);
      if (address == 3'd1) begin
        writedata[0] = ($urandom_range(0, 4) != 0);
        writedata[2] = ($urandom_range(0, 9) == 0);
      end
      event_in = $urandom_range(0, 1) == 1;
      step();
      checks++; if (readdata !== m_rd) begin errors++; $display("FAIL rand_readdata cyc %0d: got %h expected %h", i, readdata, m_rd); end
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq cyc %0d: got %b expected %b", i, irq, m_irq); end
    end
    reset = 0; bus_idle(); event_in = 0;
  endtask

  initial begin
    reset = 1; event_in = 0;
    bus_idle();
    m_ts = 0; m_evd = 0; m_ovf = 0; m_en = 0; m_ien = 0; m_thr = 1; m_snap = 0; m_rd = 0; m_irq = 0;
    @(posedge clk); #1;
    test_reset();
    test_single_event();
    test_overflow();
    test_irq_threshold();
    test_wrap();
    test_flush_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
